// File: rtl/addi_pkg.sv
// Shared constants, field layout and types for the immediate-add sequencer.
package addi_pkg;

    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXEC,
        WRITE
    } seq_state_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm_ext;
    } inst_fields_t;

    // Signed overflow of a + b: operands agree in sign, result does not.
    function automatic logic add_overflow(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] res);
        return (a[31] == b[31]) && (res[31] != a[31]);
    endfunction

endpackage

// File: rtl/addi_decode.sv
// Combinational split of an instruction word into fields, with immediate
// sign extension and opcode classification.
module addi_decode #(
    parameter logic [5:0] OPC_ADDI  = addi_pkg::OPC_ADDI,
    parameter logic [5:0] OPC_ADDIU = addi_pkg::OPC_ADDIU
) (
    input  logic [31:0]           inst_i,
    output addi_pkg::inst_fields_t fields_o,
    output logic                  legal_o,
    output logic                  is_addi_o
);
    import addi_pkg::*;

    logic [5:0] opcode;

    assign opcode           = inst_i[OPC_MSB:OPC_LSB];
    assign fields_o.rs      = inst_i[RS_MSB:RS_LSB];
    assign fields_o.rt      = inst_i[RT_MSB:RT_LSB];
    assign fields_o.imm_ext = {{16{inst_i[IMM_MSB]}}, inst_i[IMM_MSB:IMM_LSB]};

    assign is_addi_o = (opcode == OPC_ADDI);
    assign legal_o   = (opcode == OPC_ADDI) || (opcode == OPC_ADDIU);

endmodule

// File: rtl/addi_sequencer.sv
// Multi-cycle controller walking one add-immediate instruction through
// decode, register read, ALU execute and writeback.
module addi_sequencer #(
    parameter logic [5:0]  OPC_ADDI  = addi_pkg::OPC_ADDI,
    parameter logic [5:0]  OPC_ADDIU = addi_pkg::OPC_ADDIU,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic [4:0]       rf_rs_addr,
    input  logic [31:0]      rf_rs_data,
    output logic             rf_we,
    output logic [4:0]       rf_wr_addr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    output logic             done,
    output logic             illegal_op,
    output logic             ovf_trap,
    output logic [CNT_W-1:0] retired
);
    import addi_pkg::*;

    seq_state_t       state_q,   state_d;
    logic [31:0]      inst_q,    inst_d;
    logic [31:0]      rs_q,      rs_d;
    logic [31:0]      res_q,     res_d;
    logic             ovf_q,     ovf_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    inst_fields_t fields;
    logic         legal;
    logic         is_addi;

    addi_decode #(
        .OPC_ADDI  (OPC_ADDI),
        .OPC_ADDIU (OPC_ADDIU)
    ) u_decode (
        .inst_i    (inst_q),
        .fields_o  (fields),
        .legal_o   (legal),
        .is_addi_o (is_addi)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        rs_d       = rs_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        retired_d  = retired_q;
        inst_ready = 1'b0;
        rf_rs_addr = '0;
        rf_we      = 1'b0;
        rf_wr_addr = '0;
        rf_wdata   = '0;
        alu_a      = '0;
        alu_b      = '0;
        done       = 1'b0;
        illegal_op = 1'b0;
        ovf_trap   = 1'b0;

        case (state_q)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    inst_d  = inst;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = READ;
                end else begin
                    done       = 1'b1;
                    illegal_op = 1'b1;
                    state_d    = IDLE;
                end
            end
            READ: begin
                rf_rs_addr = fields.rs;
                rs_d       = rf_rs_data;
                state_d    = EXEC;
            end
            EXEC: begin
                alu_a   = rs_q;
                alu_b   = fields.imm_ext;
                res_d   = alu_result;
                ovf_d   = add_overflow(rs_q, fields.imm_ext, alu_result);
                state_d = WRITE;
            end
            WRITE: begin
                done       = 1'b1;
                ovf_trap   = is_addi && ovf_q;
                // A write to register 0 is dropped without raising a trap.
                rf_we      = !ovf_trap && (fields.rt != 5'd0);
                rf_wr_addr = fields.rt;
                rf_wdata   = res_q;
                if (rf_we) begin
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            rs_q      <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            rs_q      <= rs_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_addi_sequencer.sv
// Self-checking bench: a behavioural register file and adder surround the
// sequencer, and a reference model predicts every observable outcome.
module tb_addi_sequencer;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam int         CW       = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   inst = '0;
    logic          inst_valid = 1'b0;
    logic          inst_ready;
    logic [4:0]    rf_rs_addr;
    logic [31:0]   rf_rs_data;
    logic          rf_we;
    logic [4:0]    rf_wr_addr;
    logic [31:0]   rf_wdata;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [31:0]   alu_result;
    logic          done;
    logic          illegal_op;
    logic          ovf_trap;
    logic [CW-1:0] retired;

    logic [31:0] env_regs   [32];
    logic [31:0] model_regs [32];
    int unsigned model_retired = 0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rf_rs_data = env_regs[rf_rs_addr];
    assign alu_result = alu_a + alu_b;

    addi_sequencer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .rf_rs_addr (rf_rs_addr),
        .rf_rs_data (rf_rs_data),
        .rf_we      (rf_we),
        .rf_wr_addr (rf_wr_addr),
        .rf_wdata   (rf_wdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .done       (done),
        .illegal_op (illegal_op),
        .ovf_trap   (ovf_trap),
        .retired    (retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_reg(input int idx, input logic [31:0] v);
        env_regs[idx]   = v;
        model_regs[idx] = v;
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the first idle cycle after the instruction.
    task automatic run_inst(input logic [31:0] w, input bit hold);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic [31:0] a, b, sum;
        longint      s;
        bit          legal, trap, we;
        logic        obs_we;
        logic [4:0]  obs_addr;
        logic [31:0] obs_data;

        op    = w[31:26];
        rs    = w[25:21];
        rt    = w[20:16];
        imm   = w[15:0];
        legal = (op == OP_ADDI) || (op == OP_ADDIU);
        a     = model_regs[rs];
        s     = longint'($signed(a)) + longint'($signed(imm));
        b     = 32'(longint'($signed(imm)));
        sum   = s[31:0];
        trap  = (op == OP_ADDI) && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        we    = legal && !trap && (rt != 5'd0);

        check("ready_c0", inst_ready, 1);
        inst       = w;
        inst_valid = 1'b1;

        @(negedge clk);
        inst_valid = hold;
        inst       = $urandom();
        check("ready_c1", inst_ready, 0);
        check("done_c1", done, !legal);
        check("illegal_c1", illegal_op, !legal);
        check("we_c1", rf_we, 0);
        check("rsaddr_c1", rf_rs_addr, 0);

        if (!legal) begin
            @(negedge clk);
            check("ready_c2_illegal", inst_ready, 1);
            check("done_c2_illegal", done, 0);
            check("rsaddr_c2_illegal", rf_rs_addr, 0);
            return;
        end

        @(negedge clk);
        check("rsaddr_c2", rf_rs_addr, rs);
        check("done_c2", done, 0);
        check("we_c2", rf_we, 0);

        @(negedge clk);
        check("alu_a_c3", alu_a, a);
        check("alu_b_c3", alu_b, b);
        check("rsaddr_c3", rf_rs_addr, 0);
        check("done_c3", done, 0);

        @(negedge clk);
        check("done_c4", done, 1);
        check("we_c4", rf_we, we);
        check("trap_c4", ovf_trap, trap);
        check("illegal_c4", illegal_op, 0);
        check("wraddr_c4", rf_wr_addr, rt);
        check("wdata_c4", rf_wdata, sum);
        check("alu_a_c4", alu_a, 0);
        obs_we   = rf_we;
        obs_addr = rf_wr_addr;
        obs_data = rf_wdata;

        @(posedge clk);
        if (obs_we === 1'b1) env_regs[obs_addr] = obs_data;
        if (we) begin
            model_regs[rt] = sum;
            model_retired++;
        end

        @(negedge clk);
        check("ready_c5", inst_ready, 1);
        check("done_c5", done, 0);
        check("retired_c5", 32'(retired), model_retired % (1 << CW));
    endtask

    initial begin
        logic [5:0] op;

        for (int i = 0; i < 32; i++) set_reg(i, $urandom());
        set_reg(0, 32'h0);
        set_reg(3, 32'd5);
        set_reg(5, 32'h7FFF_FFFF);
        set_reg(9, 32'h8000_0000);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", inst_ready, 1);
        check("rst_retired", 32'(retired), 0);
        check("rst_flags", {28'd0, rf_we, done, illegal_op, ovf_trap}, 0);
        check("rst_addr", {22'd0, rf_rs_addr, rf_wr_addr}, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_alu", alu_a | alu_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic addi with negative immediate
        run_inst(mk(OP_ADDI, 5'd3, 5'd4, 16'hFFFE), 1'b0);
        check("addi_result", env_regs[4], 32'd3);
        check("addi_retired", 32'(retired), 1);

        // Overflow: trap for addi, wrap for addiu
        run_inst(mk(OP_ADDI, 5'd5, 5'd6, 16'h0001), 1'b0);
        run_inst(mk(OP_ADDIU, 5'd5, 5'd6, 16'h0001), 1'b0);
        check("addiu_wrap", env_regs[6], 32'h8000_0000);

        // Illegal opcode
        run_inst(mk(6'b000000, 5'd3, 5'd4, 16'h1234), 1'b0);

        // Write to register 0 is silently dropped
        run_inst(mk(OP_ADDIU, 5'd3, 5'd0, 16'h0042), 1'b0);
        check("r0_untouched", env_regs[0], 0);

        // Back-to-back with dependency through rt
        run_inst(mk(OP_ADDIU, 5'd3, 5'd7, 16'h0010), 1'b1);
        run_inst(mk(OP_ADDI, 5'd7, 5'd8, 16'h0001), 1'b0);
        check("dep_result", env_regs[8], 32'h16);

        // Reset during EXEC discards the instruction
        check("pre_rst_reg10", env_regs[10], model_regs[10]);
        inst       = mk(OP_ADDIU, 5'd3, 5'd10, 16'h0100);
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_exec_alu_a", alu_a, 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_done", done, 0);
        check("rst_exec_we", rf_we, 0);
        check("rst_exec_ready", inst_ready, 1);
        check("rst_exec_retired", 32'(retired), 0);
        model_retired = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exec_reg10", env_regs[10], model_regs[10]);

        // Counter wrap: preset to all-ones, then two more writes
        for (int i = 0; i < (1 << CW) - 1; i++)
            run_inst(mk(OP_ADDIU, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
                        16'($urandom())), 1'b0);
        check("retired_full", 32'(retired), (1 << CW) - 1);
        run_inst(mk(OP_ADDIU, 5'd1, 5'd2, 16'h0003), 1'b0);
        run_inst(mk(OP_ADDIU, 5'd2, 5'd11, 16'h0004), 1'b0);
        check("retired_wrap", 32'(retired), 1);

        // Randomised mix including overflow-prone registers and bad opcodes
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    op = OP_ADDI;
                2:       op = OP_ADDIU;
                default: op = 6'($urandom());
            endcase
            run_inst(mk(op, 5'($urandom()), 5'($urandom()), 16'($urandom())), 1'b0);
        end

        for (int i = 0; i < 32; i++) check("final_regs", env_regs[i], model_regs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
